// File: rtl/teclado_pkg.sv
// Key codes and FSM state type shared by the keypad scan driver and the
// code-entry stage.
package teclado_pkg;

    localparam logic [4:0] K_FA   = 5'd10;
    localparam logic [4:0] K_FB   = 5'd11;
    localparam logic [4:0] K_FC   = 5'd12;
    localparam logic [4:0] K_FD   = 5'd13;
    localparam logic [4:0] K_HASH = 5'd14;
    localparam logic [4:0] K_STAR = 5'd15;
    localparam logic [4:0] K_NONE = 5'd16;
    localparam logic [4:0] K_INV  = 5'd17;

    typedef enum logic {
        IDLE,
        WAIT_REL
    } estado_t;

    // Function key A..D mapped to 0..3.
    function automatic logic [1:0] id_funcion(input logic [3:0] tecla);
        logic [3:0] rel;
        rel = tecla - K_FA[3:0];
        return rel[1:0];
    endfunction

endpackage

// File: rtl/detector_liberacion.sv
// One-action-per-press filter: accepts a key strobe in IDLE, then waits for
// REL_CYC consecutive strobe-free cycles before accepting another.
module detector_liberacion
    import teclado_pkg::*;
#(
    parameter int REL_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] digito,
    input  logic       cambio_digito,
    output logic       acepta,
    output logic [3:0] tecla
);

    localparam int CW = $clog2(REL_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(REL_CYC);
    localparam logic [CW-1:0] CNT_ULT = CW'(REL_CYC - 1);

    estado_t       estado, estado_sig;
    logic [CW-1:0] cnt;
    logic          acepta_c;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_sig;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves estado_sig
        // unassigned, which would infer a latch.
        estado_sig = estado;
        case (estado)
            IDLE:     if (cambio_digito && digito < K_NONE) estado_sig = WAIT_REL;
            WAIT_REL: if (!cambio_digito && cnt == CNT_ULT) estado_sig = IDLE;
            default:  estado_sig = IDLE;
        endcase
    end

    always_comb begin
        acepta_c = (estado == IDLE) && cambio_digito && (digito < K_NONE);
    end

    // Release counter: any strobe restarts it, and it saturates at REL_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (estado == IDLE || cambio_digito) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acepta <= 1'b0;
            tecla  <= '0;
        end else begin
            acepta <= acepta_c;
            if (acepta_c) tecla <= digito[3:0];
        end
    end

endmodule

// File: rtl/captura_codigo.sv
// Keypad code-entry stage: builds a BCD code from debounced key presses,
// with backspace (#), enter (*) and A..D function-key events.
module captura_codigo
    import teclado_pkg::*;
#(
    parameter int N_DIG   = 4,
    parameter int REL_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         digito,
    input  logic               cambio_digito,
    output logic [4*N_DIG-1:0] codigo,
    output logic [3:0]         n_dig,
    output logic [4*N_DIG-1:0] codigo_final,
    output logic               codigo_valido,
    output logic               func_valido,
    output logic [1:0]         func_id,
    output logic               error
);

    localparam int         W     = 4 * N_DIG;
    localparam logic [3:0] N_MAX = 4'(N_DIG);

    logic       acepta;
    logic [3:0] tecla;

    detector_liberacion #(.REL_CYC(REL_CYC)) u_det (
        .clk           (clk),
        .rst_n         (rst_n),
        .digito        (digito),
        .cambio_digito (cambio_digito),
        .acepta        (acepta),
        .tecla         (tecla)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codigo        <= '0;
            n_dig         <= '0;
            codigo_final  <= '0;
            codigo_valido <= 1'b0;
            func_valido   <= 1'b0;
            func_id       <= '0;
            error         <= 1'b0;
        end else begin
            // Event outputs are single-cycle pulses unless re-asserted below.
            codigo_valido <= 1'b0;
            func_valido   <= 1'b0;
            error         <= 1'b0;
            if (acepta) begin
                if (tecla <= 4'd9) begin
                    if (n_dig < N_MAX) begin
                        codigo <= {codigo[W-5:0], tecla};
                        n_dig  <= n_dig + 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                end else if (tecla == K_HASH[3:0]) begin
                    if (n_dig != 4'd0) begin
                        codigo <= {4'h0, codigo[W-1:4]};
                        n_dig  <= n_dig - 1'b1;
                    end
                end else if (tecla == K_STAR[3:0]) begin
                    if (n_dig != 4'd0) begin
                        codigo_final  <= codigo;
                        codigo_valido <= 1'b1;
                        codigo        <= '0;
                        n_dig         <= '0;
                    end else begin
                        error <= 1'b1;
                    end
                end else begin
                    func_id     <= id_funcion(tecla);
                    func_valido <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_captura_codigo.sv
// Directed bench for captura_codigo: scripted key presses with hand-computed
// buffer contents and pulse counts.
module tb_captura_codigo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  digito = 5'd16;
    logic        cambio_digito = 1'b0;
    logic [15:0] codigo, codigo_final;
    logic [3:0]  n_dig;
    logic        codigo_valido, func_valido, error;
    logic [1:0]  func_id;

    int n_chk = 0;
    int n_ok  = 0;
    int cv_cnt = 0, fv_cnt = 0, err_cnt = 0, multi_cnt = 0;

    captura_codigo #(.N_DIG(4), .REL_CYC(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digito        (digito),
        .cambio_digito (cambio_digito),
        .codigo        (codigo),
        .n_dig         (n_dig),
        .codigo_final  (codigo_final),
        .codigo_valido (codigo_valido),
        .func_valido   (func_valido),
        .func_id       (func_id),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (codigo_valido) cv_cnt++;
            if (func_valido)   fv_cnt++;
            if (error)         err_cnt++;
            if (int'(codigo_valido) + int'(func_valido) + int'(error) > 1) multi_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_counts();
        cv_cnt = 0; fv_cnt = 0; err_cnt = 0;
    endtask

    task automatic strobe(input logic [4:0] k);
        @(negedge clk);
        digito = k;
        cambio_digito = 1'b1;
        @(negedge clk);
        cambio_digito = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] k, input int n_strobes);
        for (int i = 0; i < n_strobes; i++) strobe(k);
        repeat (10) @(negedge clk);
        digito = 5'd16;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset codigo", codigo, 0);
        check("reset n_dig", n_dig, 0);
        check("reset final", codigo_final, 0);
        check("reset pulses", {codigo_valido, func_valido, error, func_id}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1,2,3,4 then enter
        clear_counts();
        press(5'd1, 3); press(5'd2, 3); press(5'd3, 3); press(5'd4, 3);
        check("t1 codigo", codigo, 16'h1234);
        check("t1 n_dig", n_dig, 4);
        press(5'd15, 3);
        check("t1 valido count", cv_cnt, 1);
        check("t1 final", codigo_final, 16'h1234);
        check("t1 codigo clr", codigo, 0);
        check("t1 n_dig clr", n_dig, 0);
        check("t1 no error", err_cnt, 0);

        // long hold: one accept only
        clear_counts();
        press(5'd5, 10);
        check("t2 codigo", codigo, 16'h0005);
        check("t2 n_dig", n_dig, 1);
        press(5'd15, 3);
        check("t2 final", codigo_final, 16'h0005);

        // overflow on fifth digit
        clear_counts();
        press(5'd7, 3); press(5'd8, 3); press(5'd9, 3); press(5'd0, 3);
        check("t3 no error yet", err_cnt, 0);
        press(5'd1, 3);
        check("t3 codigo", codigo, 16'h7890);
        check("t3 n_dig", n_dig, 4);
        check("t3 error count", err_cnt, 1);
        press(5'd15, 3);
        check("t3 final", codigo_final, 16'h7890);

        // backspace
        clear_counts();
        press(5'd4, 3); press(5'd2, 3); press(5'd14, 3);
        check("t4 codigo", codigo, 16'h0004);
        check("t4 n_dig", n_dig, 1);
        press(5'd14, 3); press(5'd14, 3);
        check("t4 codigo empty", codigo, 0);
        check("t4 n_dig empty", n_dig, 0);
        check("t4 no error", err_cnt, 0);

        // enter on empty, then function keys
        clear_counts();
        press(5'd15, 3);
        check("t5 error count", err_cnt, 1);
        check("t5 no valido", cv_cnt, 0);
        check("t5 final held", codigo_final, 16'h7890);
        press(5'd12, 3);
        check("t5 func count", fv_cnt, 1);
        check("t5 func_id C", func_id, 2);
        press(5'd13, 3);
        check("t5 func_id D", func_id, 3);
        check("t5 codigo untouched", codigo, 0);

        // reset mid-press while 6 is held
        press(5'd3, 3);
        check("t6 pre codigo", codigo, 16'h0003);
        strobe(5'd6);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6 rst codigo", codigo, 0);
        check("t6 rst n_dig", n_dig, 0);
        check("t6 rst final", codigo_final, 0);
        check("t6 rst func_id", func_id, 0);
        rst_n = 1'b1;
        clear_counts();
        press(5'd6, 3);
        check("t6 codigo", codigo, 16'h0006);
        check("t6 n_dig", n_dig, 1);
        press(5'd16, 3);
        press(5'd17, 3);
        check("t6 none ignored", n_dig, 1);
        check("t6 none codigo", codigo, 16'h0006);
        check("t6 no pulses", cv_cnt + fv_cnt + err_cnt, 0);
        check("exclusive pulses", multi_cnt, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
